// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, ALU op codes,
// datapath mux selects and the main FSM state type.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } ctrl_state_t;

  function automatic logic is_supported_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

  function automatic logic is_wait_state(input ctrl_state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait-cycle counter for memory handshakes; expired is raised once the
// count reaches MEM_TIMEOUT (never when MEM_TIMEOUT is 0).
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CW = (MEM_TIMEOUT > 32'd0) ? $clog2(MEM_TIMEOUT + 32'd1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear wins, otherwise count up until saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CW{1'b0}};
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (MEM_TIMEOUT != 32'd0) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode, execute,
// memory and write-back, and decodes all datapath selects and strobes from state.
module multicycle_main_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic       bus_err
);

  ctrl_state_t state_q;
  ctrl_state_t state_d;
  logic        in_wait;
  logic        expired;
  logic        timeout;
  logic        pc_update;
  logic        branch;

  assign in_wait = is_wait_state(state_q);
  // mem_ready beats an expiring counter in the same cycle
  assign timeout = in_wait & expired & ~mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (~in_wait | mem_ready | timeout),
    .inc     (in_wait & ~mem_ready & ~timeout),
    .expired (expired)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_d = S_MEMREAD;
        end else if (op == OP_SW) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMREAD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = (mem_ready || timeout) ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // output decode; everything held at zero while reset is asserted
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALU_OP_ADD;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    if (rst_n) begin
      bus_err = timeout;
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          ir_write   = mem_ready;
          pc_update  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_IMM;
          illegal_op = ~is_supported_op(op);
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_MEM;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_op    = ALU_OP_FUNCT;
        end
        S_EXECI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_OP_FUNCT;
        end
        S_ALUWB: begin
          result_src = RES_ALUOUT;
          reg_write  = 1'b1;
        end
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_update = 1'b1;
        end
        S_BEQ: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_op    = ALU_OP_SUB;
          branch    = 1'b1;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end else begin
      bus_err = 1'b0;
    end
    pc_write = pc_update | (branch & zero);
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Cycle-by-cycle check of the main control FSM outputs against expectations
// built from the per-state output table, with MEM_TIMEOUT = 4.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic       illegal_op, bus_err;

  always #5 clk = ~clk;

  multicycle_main_control #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .bus_err    (bus_err)
  );

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_BAD = 7'b0000000;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  wire [15:0] obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                     alu_src_a, alu_src_b, result_src, alu_op, illegal_op, bus_err};

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] ov(input logic mreq, input logic mwr, input logic adr,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] rs, input logic [1:0] ao,
                                     input logic ill, input logic be);
    return {mreq, mwr, adr, irw, pcw, rw, sa, sb, rs, ao, ill, be};
  endfunction

  task automatic cyc(input string tag, input logic rst, input logic [6:0] o,
                     input logic z, input logic rdy, input logic [15:0] e);
    exp_t item;
    @(negedge clk);
    rst_n     = rst;
    op        = o;
    zero      = z;
    mem_ready = rdy;
    item.tag  = tag;
    item.v    = e;
    sb_q.push_back(item);
    #1;
    item = sb_q.pop_front();
    check_eq(item.tag, obs, item.v);
  endtask

  logic [15:0] e_zero, e_f1, e_f0, e_f0e, e_dec, e_ill, e_exr, e_exi, e_awb;
  logic [15:0] e_madr, e_mrd, e_mwb, e_mwr, e_mwre, e_jal, e_beq1, e_beq0;

  initial begin
    e_zero = 16'h0000;
    e_f1   = ov(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0);
    e_f0   = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0);
    e_f0e  = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b1);
    e_dec  = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    e_ill  = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
    e_exr  = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
    e_exi  = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0);
    e_awb  = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    e_madr = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    e_mrd  = ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    e_mwb  = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    e_mwr  = ov(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    e_mwre = ov(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    e_jal  = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    e_beq1 = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
    e_beq0 = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0);

    // reset hold and release into FETCH
    cyc("rst_hold0", 1'b0, T_R, 1'b1, 1'b1, e_zero);
    cyc("rst_hold1", 1'b0, T_R, 1'b1, 1'b1, e_zero);
    cyc("rst_fetch", 1'b1, T_R, 1'b0, 1'b1, e_f1);

    // add: DECODE, EXECR, ALUWB, FETCH
    cyc("add_dec",   1'b1, T_R, 1'b0, 1'b1, e_dec);
    cyc("add_execr", 1'b1, T_R, 1'b0, 1'b1, e_exr);
    cyc("add_aluwb", 1'b1, T_R, 1'b0, 1'b1, e_awb);
    cyc("add_fetch", 1'b1, T_R, 1'b0, 1'b1, e_f1);

    // addi
    cyc("addi_dec",   1'b1, T_I, 1'b0, 1'b1, e_dec);
    cyc("addi_execi", 1'b1, T_I, 1'b0, 1'b1, e_exi);
    cyc("addi_aluwb", 1'b1, T_I, 1'b0, 1'b1, e_awb);
    cyc("addi_fetch", 1'b1, T_I, 1'b0, 1'b1, e_f1);

    // lw with three wait cycles in MEMREAD
    cyc("lw_dec",    1'b1, T_LW, 1'b0, 1'b1, e_dec);
    cyc("lw_memadr", 1'b1, T_LW, 1'b0, 1'b1, e_madr);
    for (int i = 0; i < 3; i++) cyc($sformatf("lw_wait%0d", i), 1'b1, T_LW, 1'b0, 1'b0, e_mrd);
    cyc("lw_rd_done", 1'b1, T_LW, 1'b0, 1'b1, e_mrd);
    cyc("lw_memwb",   1'b1, T_LW, 1'b0, 1'b1, e_mwb);
    cyc("lw_fetch",   1'b1, T_LW, 1'b0, 1'b1, e_f1);

    // sw completing immediately, then one fetch wait
    cyc("sw_dec",      1'b1, T_SW, 1'b0, 1'b1, e_dec);
    cyc("sw_memadr",   1'b1, T_SW, 1'b0, 1'b1, e_madr);
    cyc("sw_memwrite", 1'b1, T_SW, 1'b0, 1'b1, e_mwr);
    cyc("fetch_wait",  1'b1, T_SW, 1'b0, 1'b0, e_f0);
    cyc("fetch_done",  1'b1, T_SW, 1'b0, 1'b1, e_f1);

    // beq taken and not taken
    cyc("beq1_dec",   1'b1, T_BEQ, 1'b1, 1'b1, e_dec);
    cyc("beq1_beq",   1'b1, T_BEQ, 1'b1, 1'b1, e_beq1);
    cyc("beq1_fetch", 1'b1, T_BEQ, 1'b1, 1'b1, e_f1);
    cyc("beq0_dec",   1'b1, T_BEQ, 1'b0, 1'b1, e_dec);
    cyc("beq0_beq",   1'b1, T_BEQ, 1'b0, 1'b1, e_beq0);
    cyc("beq0_fetch", 1'b1, T_BEQ, 1'b0, 1'b1, e_f1);

    // jal
    cyc("jal_dec",   1'b1, T_JAL, 1'b0, 1'b1, e_dec);
    cyc("jal_jal",   1'b1, T_JAL, 1'b0, 1'b1, e_jal);
    cyc("jal_aluwb", 1'b1, T_JAL, 1'b0, 1'b1, e_awb);
    cyc("jal_fetch", 1'b1, T_JAL, 1'b0, 1'b1, e_f1);

    // unsupported opcode
    cyc("ill_dec",   1'b1, T_BAD, 1'b0, 1'b1, e_ill);
    cyc("ill_fetch", 1'b1, T_BAD, 1'b0, 1'b1, e_f1);

    // sw timeout: four waits, bus_err on the fifth, then FETCH with mem_write low
    cyc("swto_dec",    1'b1, T_SW, 1'b0, 1'b1, e_dec);
    cyc("swto_memadr", 1'b1, T_SW, 1'b0, 1'b1, e_madr);
    for (int i = 0; i < 4; i++) cyc($sformatf("swto_wait%0d", i), 1'b1, T_SW, 1'b0, 1'b0, e_mwr);
    cyc("swto_buserr", 1'b1, T_SW, 1'b0, 1'b0, e_mwre);
    cyc("swto_fetch",  1'b1, T_SW, 1'b0, 1'b0, e_f0);
    cyc("swto_refetch", 1'b1, T_SW, 1'b0, 1'b1, e_f1);

    // mem_ready coinciding with the expired counter wins
    cyc("swco_dec",    1'b1, T_SW, 1'b0, 1'b1, e_dec);
    cyc("swco_memadr", 1'b1, T_SW, 1'b0, 1'b1, e_madr);
    for (int i = 0; i < 4; i++) cyc($sformatf("swco_wait%0d", i), 1'b1, T_SW, 1'b0, 1'b0, e_mwr);
    cyc("swco_ready",  1'b1, T_SW, 1'b0, 1'b1, e_mwr);

    // fetch timeout restarts the fetch
    for (int i = 0; i < 4; i++) cyc($sformatf("fto_wait%0d", i), 1'b1, T_SW, 1'b0, 1'b0, e_f0);
    cyc("fto_buserr",  1'b1, T_SW, 1'b0, 1'b0, e_f0e);
    cyc("fto_restart", 1'b1, T_SW, 1'b0, 1'b0, e_f0);
    cyc("fto_done",    1'b1, T_SW, 1'b0, 1'b1, e_f1);

    // reset asserted in MEMWRITE kills the access immediately
    cyc("swrst_dec",    1'b1, T_SW, 1'b0, 1'b1, e_dec);
    cyc("swrst_memadr", 1'b1, T_SW, 1'b0, 1'b1, e_madr);
    cyc("swrst_mw",     1'b1, T_SW, 1'b0, 1'b0, e_mwr);
    cyc("swrst_reset",  1'b0, T_SW, 1'b0, 1'b1, e_zero);
    cyc("swrst_fetch",  1'b1, T_SW, 1'b0, 1'b1, e_f1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
